// File: rtl/cnt_pkg.sv
// Shared constants for the multi-digit counter: legal digit radices, the
// seven-segment character set and the per-cycle counter operation.
package cnt_pkg;

    localparam int BASE_DEC = 10;
    localparam int BASE_HEX = 16;

    // Segment order is {dp, g, f, e, d, c, b, a}; dp is never lit.
    localparam logic [7:0] SEG_LUT [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_LOAD,
        OP_INC,
        OP_DEC
    } cnt_op_e;

    function automatic bit base_is_legal(input int base);
        return (base == BASE_DEC) || (base == BASE_HEX);
    endfunction

endpackage

// File: rtl/cnt_multi_digit_if.sv
// Control, load and display signals of the multi-digit counter; the counter
// is the slave, whoever drives the controls and reads the display is the master.
interface cnt_multi_digit_if #(
    parameter int NDIG = 2
) ();

    logic              en;
    logic              key_n;
    logic              tick;
    logic              up;
    logic              load;
    logic [4*NDIG-1:0] load_val;
    logic [4*NDIG-1:0] cnt_val;
    logic              carry;
    logic [NDIG-1:0]   scan;
    logic [7:0]        seg;

    modport master (
        output en, key_n, tick, up, load, load_val,
        input  cnt_val, carry, scan, seg
    );

    modport slave (
        input  en, key_n, tick, up, load, load_val,
        output cnt_val, carry, scan, seg
    );

endinterface

// File: rtl/seg7_dec.sv
// Hex digit to seven-segment pattern, purely combinational.
module seg7_dec
    import cnt_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [7:0] seg_o
);

    assign seg_o = SEG_LUT[digit_i];

endmodule

// File: rtl/cnt_multi_digit.sv
// Multi-digit decimal/hex up-down counter driven by debounced-free key edges or
// ticks, with load, wrap or saturate at the limits, and a multiplexed display.
module cnt_multi_digit
    import cnt_pkg::*;
#(
    parameter int NDIG = 2,
    parameter int BASE = 16,
    parameter int SAT  = 0
) (
    input  logic             clk10hz,
    input  logic             rst,
    cnt_multi_digit_if.slave bus
);

    localparam int            W        = 4 * NDIG;
    localparam int            IW       = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [3:0]    DMAX     = base_is_legal(BASE) ? 4'(BASE - 1) : 4'hF;
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

    logic          key_s1_q, key_s2_q, key_prev_q;
    logic [W-1:0]  cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          key_ev, ev, ripple;
    logic [3:0]    nib, sel_digit;
    cnt_op_e       op;

    // Idle key level is 1, so a press is a 1 -> 0 step of the synchronised input.
    assign key_ev = key_prev_q & ~key_s2_q;
    assign ev     = bus.en ? key_ev : bus.tick;

    // NOTE: every signal driven in always_comb gets a default first, otherwise
    // any path that skips an assignment infers a latch.
    always_comb begin
        op = OP_HOLD;
        if (bus.load) begin
            op = OP_LOAD;
        end else if (ev) begin
            op = bus.up ? OP_INC : OP_DEC;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        carry_d = 1'b0;
        ripple  = 1'b1;
        nib     = '0;
        unique case (op)
            OP_LOAD: begin
                for (int i = 0; i < NDIG; i++) begin
                    nib            = bus.load_val[4*i +: 4];
                    cnt_d[4*i +: 4] = (nib > DMAX) ? DMAX : nib;
                end
            end
            OP_INC: begin
                for (int i = 0; i < NDIG; i++) begin
                    if (ripple) begin
                        if (cnt_q[4*i +: 4] == DMAX) begin
                            cnt_d[4*i +: 4] = 4'h0;
                        end else begin
                            cnt_d[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                            ripple          = 1'b0;
                        end
                    end
                end
                if (ripple) begin
                    carry_d = 1'b1;
                    if (SAT != 0) cnt_d = cnt_q;
                end
            end
            OP_DEC: begin
                for (int i = 0; i < NDIG; i++) begin
                    if (ripple) begin
                        if (cnt_q[4*i +: 4] == 4'h0) begin
                            cnt_d[4*i +: 4] = DMAX;
                        end else begin
                            cnt_d[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
                            ripple          = 1'b0;
                        end
                    end
                end
                // Ripple out of the top digit means the counter was all-zero.
                if (ripple) begin
                    carry_d = 1'b1;
                    if (SAT != 0) cnt_d = cnt_q;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    assign idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk10hz) begin
        if (!rst) begin
            key_s1_q   <= 1'b1;
            key_s2_q   <= 1'b1;
            key_prev_q <= 1'b1;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
        end else begin
            key_s1_q   <= bus.key_n;
            key_s2_q   <= key_s1_q;
            key_prev_q <= key_s2_q;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            idx_q      <= idx_d;
        end
    end

    assign bus.cnt_val = cnt_q;
    assign bus.carry   = carry_q;
    assign bus.scan    = NDIG'(1) << idx_q;
    assign sel_digit   = cnt_q[4*idx_q +: 4];

    seg7_dec u_seg7_dec (
        .digit_i (sel_digit),
        .seg_o   (bus.seg)
    );

endmodule

// File: tb/tb_cnt_multi_digit.sv
// Scoreboard bench: four counter configurations share one stimulus stream and
// are compared each cycle against an integer-valued reference model.
module tb_cnt_multi_digit;

    logic        clk10hz = 1'b0;
    logic        rst     = 1'b0;
    logic        en      = 1'b0;
    logic        key_n   = 1'b1;
    logic        tick    = 1'b0;
    logic        up      = 1'b1;
    logic        load    = 1'b0;
    logic [15:0] lv      = '0;

    always #5 clk10hz = ~clk10hz;

    cnt_multi_digit_if #(.NDIG(2)) if_a ();
    cnt_multi_digit_if #(.NDIG(2)) if_b ();
    cnt_multi_digit_if #(.NDIG(2)) if_c ();
    cnt_multi_digit_if #(.NDIG(4)) if_d ();

    assign if_a.en = en;    assign if_a.key_n = key_n; assign if_a.tick = tick;
    assign if_a.up = up;    assign if_a.load  = load;  assign if_a.load_val = lv[7:0];
    assign if_b.en = en;    assign if_b.key_n = key_n; assign if_b.tick = tick;
    assign if_b.up = up;    assign if_b.load  = load;  assign if_b.load_val = lv[7:0];
    assign if_c.en = en;    assign if_c.key_n = key_n; assign if_c.tick = tick;
    assign if_c.up = up;    assign if_c.load  = load;  assign if_c.load_val = lv[7:0];
    assign if_d.en = en;    assign if_d.key_n = key_n; assign if_d.tick = tick;
    assign if_d.up = up;    assign if_d.load  = load;  assign if_d.load_val = lv;

    cnt_multi_digit #(.NDIG(2), .BASE(16), .SAT(0)) u_hex2 (.clk10hz(clk10hz), .rst(rst), .bus(if_a.slave));
    cnt_multi_digit #(.NDIG(2), .BASE(10), .SAT(0)) u_dec2 (.clk10hz(clk10hz), .rst(rst), .bus(if_b.slave));
    cnt_multi_digit #(.NDIG(2), .BASE(10), .SAT(1)) u_sat2 (.clk10hz(clk10hz), .rst(rst), .bus(if_c.slave));
    cnt_multi_digit #(.NDIG(4), .BASE(16), .SAT(0)) u_hex4 (.clk10hz(clk10hz), .rst(rst), .bus(if_d.slave));

    localparam logic [7:0] SEG_REF [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    typedef struct packed {
        logic [15:0] cnt;
        logic        carry;
        logic [3:0]  scan;
        logic [7:0]  seg;
    } obs_t;
    typedef obs_t [3:0] obs_set_t;

    typedef struct {
        int ndig;
        int base;
        bit sat;
        int val;
        int idx;
        bit carry;
    } mdl_t;

    obs_set_t exp_q [$];
    mdl_t     mdl [4];
    bit       key_hist [$];
    int       n_checks = 0;
    int       n_fail   = 0;
    int       n_cyc    = 0;
    bit       armed    = 1'b0;

    function automatic string dut_name(input int i);
        case (i)
            0:       return "hex2";
            1:       return "dec2";
            2:       return "dec2_sat";
            default: return "hex4";
        endcase
    endfunction

    function automatic int max_val(input int ndig, input int base);
        int m = 1;
        for (int d = 0; d < ndig; d++) m = m * base;
        return m - 1;
    endfunction

    function automatic logic [15:0] digits_of(input int ndig, input int base, input int val);
        logic [15:0] r = '0;
        int          w = 1;
        for (int d = 0; d < ndig; d++) begin
            r[4*d +: 4] = 4'((val / w) % base);
            w = w * base;
        end
        return r;
    endfunction

    function automatic int value_of_load(input int ndig, input int base, input logic [15:0] v);
        int acc = 0;
        int w   = 1;
        int nib;
        for (int d = 0; d < ndig; d++) begin
            nib = int'(v[4*d +: 4]);
            if (nib >= base) nib = base - 1;
            acc = acc + nib * w;
            w   = w * base;
        end
        return acc;
    endfunction

    // Advance the reference by one clock edge and queue what each DUT must show.
    task automatic model_edge(input bit r, input bit e, input bit k, input bit t,
                              input bit u, input bit l, input logic [15:0] v);
        bit          kev, ev;
        int          mx;
        logic [15:0] c;
        obs_set_t    es;
        if (!r) begin
            key_hist = '{1'b1, 1'b1, 1'b1};
            for (int i = 0; i < 4; i++) begin
                mdl[i].val   = 0;
                mdl[i].idx   = 0;
                mdl[i].carry = 1'b0;
            end
        end else begin
            // A press counts two edges after the edge that first samples it low.
            key_hist.push_back(k);
            kev = (key_hist[1] == 1'b0) && (key_hist[0] == 1'b1);
            void'(key_hist.pop_front());
            ev = e ? kev : t;
            for (int i = 0; i < 4; i++) begin
                mx           = max_val(mdl[i].ndig, mdl[i].base);
                mdl[i].carry = 1'b0;
                if (l) begin
                    mdl[i].val = value_of_load(mdl[i].ndig, mdl[i].base, v);
                end else if (ev && u) begin
                    if (mdl[i].val == mx) begin
                        mdl[i].carry = 1'b1;
                        if (!mdl[i].sat) mdl[i].val = 0;
                    end else begin
                        mdl[i].val = mdl[i].val + 1;
                    end
                end else if (ev && !u) begin
                    if (mdl[i].val == 0) begin
                        mdl[i].carry = 1'b1;
                        if (!mdl[i].sat) mdl[i].val = mx;
                    end else begin
                        mdl[i].val = mdl[i].val - 1;
                    end
                end
                mdl[i].idx = (mdl[i].idx + 1) % mdl[i].ndig;
            end
        end
        for (int i = 0; i < 4; i++) begin
            c           = digits_of(mdl[i].ndig, mdl[i].base, mdl[i].val);
            es[i].cnt   = c;
            es[i].carry = mdl[i].carry;
            es[i].scan  = 4'(1 << mdl[i].idx);
            es[i].seg   = SEG_REF[c[4*mdl[i].idx +: 4]];
        end
        exp_q.push_back(es);
    endtask

    task automatic cyc(input bit r, input bit e, input bit k, input bit t,
                       input bit u, input bit l, input logic [15:0] v);
        @(negedge clk10hz);
        rst   = r;
        en    = e;
        key_n = k;
        tick  = t;
        up    = u;
        load  = l;
        lv    = v;
        model_edge(r, e, k, t, u, l, v);
        armed = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, 1'b0, 1'b1, 1'b0, up, 1'b0, 16'h0000);
    endtask

    task automatic check(input string name, input int dut, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s cycle %0d: got %h, required %h",
                     dut_name(dut), name, n_cyc, act, exp);
        end
    endtask

    initial begin : monitor
        obs_set_t act;
        obs_set_t es;
        forever begin
            @(posedge clk10hz);
            #1;
            if (armed) begin
                act[0] = {8'h00, if_a.cnt_val, if_a.carry, 2'b00, if_a.scan, if_a.seg};
                act[1] = {8'h00, if_b.cnt_val, if_b.carry, 2'b00, if_b.scan, if_b.seg};
                act[2] = {8'h00, if_c.cnt_val, if_c.carry, 2'b00, if_c.scan, if_c.seg};
                act[3] = {if_d.cnt_val, if_d.carry, if_d.scan, if_d.seg};
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard cycle %0d: got no expectation, required one", n_cyc);
                end else begin
                    es = exp_q.pop_front();
                    for (int i = 0; i < 4; i++) begin
                        check("cnt_val", i, 32'(act[i].cnt),   32'(es[i].cnt));
                        check("carry",   i, 32'(act[i].carry), 32'(es[i].carry));
                        check("scan",    i, 32'(act[i].scan),  32'(es[i].scan));
                        check("seg",     i, 32'(act[i].seg),   32'(es[i].seg));
                    end
                end
                n_cyc++;
            end
        end
    end

    initial begin : stimulus
        int hold;
        bit kn, e, u;
        mdl[0] = '{ndig: 2, base: 16, sat: 1'b0, val: 0, idx: 0, carry: 1'b0};
        mdl[1] = '{ndig: 2, base: 10, sat: 1'b0, val: 0, idx: 0, carry: 1'b0};
        mdl[2] = '{ndig: 2, base: 10, sat: 1'b1, val: 0, idx: 0, carry: 1'b0};
        mdl[3] = '{ndig: 4, base: 16, sat: 1'b0, val: 0, idx: 0, carry: 1'b0};

        // Reset wins over a simultaneous load and tick.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1234);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
        idle(2);

        // Digit ripple, full wrap with a one-cycle carry.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h000F);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        idle(1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h00FF);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        idle(2);

        // Underflow, saturation at the top, and load beating a tick with clamping.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        idle(1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0099);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        idle(1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h003C);
        idle(1);

        // One long key press with ticks that must be ignored.
        repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b0, i[0], 1'b1, 1'b0, 16'h0000);
        repeat (5) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);

        // Reset in the middle of counting.
        repeat (5) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        idle(2);

        // Display scan across a four-digit value.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1A2F);
        idle(6);

        // Random traffic with boundary-heavy load values.
        hold = 0;
        kn   = 1'b1;
        e    = 1'b0;
        u    = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            bit          r, t, l;
            logic [15:0] v;
            if (hold == 0) begin
                kn   = ~kn;
                hold = $urandom_range(1, 25);
            end else begin
                hold--;
            end
            if ($urandom_range(0, 39) == 0) e = ~e;
            if ($urandom_range(0, 59) == 0) u = ~u;
            t = ($urandom_range(0, 2) == 0);
            l = ($urandom_range(0, 29) == 0);
            r = ($urandom_range(0, 199) != 0);
            case ($urandom_range(0, 3))
                0:       v = 16'h0000;
                1:       v = 16'hFFFF;
                2:       v = 16'h9999;
                default: v = 16'($urandom);
            endcase
            cyc(r, e, kn, t, u, l, v);
        end

        @(posedge clk10hz);
        #2;
        armed = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d unchecked entries, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cnt_multi_digit.md
CNT_MULTI_DIGIT -- requirements
Module: cnt_multi_digit

Interface
REQ-001 SHALL have parameter NDIG, default 2, number of 4-bit digits (1..6).
REQ-002 SHALL have parameter BASE, default 16, digit radix; only 10 or 16 legal.
REQ-003 SHALL have parameter SAT, default 0; 0 = wrap at limits, 1 = saturate at limits.
REQ-004 SHALL have port clk10hz  input  1  sole clock, all flops on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port en  input  1  source select: 1 = key events, 0 = tick events.
REQ-007 SHALL have port key_n  input  1  raw pushbutton, active-low, asynchronous.
REQ-008 SHALL have port tick  input  1  one-cycle count pulse, already in the clk10hz domain.
REQ-009 SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-010 SHALL have port load  input  1  synchronous load strobe.
REQ-011 SHALL have port load_val  input  4*NDIG  load value, digit 0 in bits [3:0].
REQ-012 SHALL have port cnt_val  output  4*NDIG  registered count, digit 0 in bits [3:0].
REQ-013 SHALL have port carry  output  1  one-cycle registered pulse on overflow or underflow.
REQ-014 SHALL have port scan  output  NDIG  one-hot digit select, bit i = digit i.
REQ-015 SHALL have port seg  output  8  segment pattern for the selected digit, bit0 = a, bit7 = dp (always 0).

Function
REQ-016 SHALL synchronise key_n through two flops, then detect a falling edge: previous synchronised value 1, current 0.
REQ-017 SHALL produce exactly one key event per press, 3 rising edges after key_n is first sampled low, with no repeat while the key is held.
REQ-018 SHALL define ev = en ? key event : tick; ev SHALL be sampled every cycle and acted on in the same cycle.
REQ-019 SHALL apply priority rst > load > ev.
REQ-020 SHALL, on load, set each digit to its load_val nibble, clamping any nibble >= BASE to BASE-1; load SHALL NOT pulse carry.
REQ-021 SHALL, on ev with up=1, increment digit 0; a digit at BASE-1 becomes 0 and increments the next digit, rippling combinationally; all digits SHALL update on the same edge.
REQ-022 SHALL, on ev with up=0, decrement digit 0; a digit at 0 becomes BASE-1 and borrows from the next digit.
REQ-023 SHALL, with SAT=0, wrap all-max to all-zero on up (all-zero to all-max on down) and pulse carry for one cycle.
REQ-024 SHALL, with SAT=1, hold cnt_val at all-max on up (all-zero on down) and pulse carry for one cycle on each attempted overflow or underflow.
REQ-025 SHALL hold cnt_val and keep carry=0 on cycles with no ev and no load.
REQ-026 SHALL use a scan index that advances 0..NDIG-1 every cycle and wraps to 0; scan SHALL be the one-hot decode of the index.
REQ-027 SHALL drive seg combinationally from the indexed digit using standard hex patterns (0=3F, 1=06, ... 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71).
REQ-028 SHALL ignore a change of en mid-press; only edges detected after the change SHALL count while en=1.

Reset
REQ-029 SHALL, on a clock edge with rst=0, set cnt_val=0, carry=0, scan index=0 (scan=...01, seg=3F), and both key synchroniser flops and the previous-key flop to 1.
REQ-030 SHALL give reset priority over simultaneous load or ev, and SHALL drop any pending key edge.

Structure
REQ-031 SHALL place the 16 segment constants and the legal BASE values in the shared package cnt_pkg.
REQ-032 SHALL implement segment decoding in one combinational sub-module, seg7_dec (4-bit in, 8-bit out).

Verification
REQ-033 SHALL cover: NDIG=2, BASE=16, up, 0x0F + tick -> 0x10, carry=0; 0xFF + tick -> 0x00, carry=1 for exactly one cycle.
REQ-034 SHALL cover: BASE=10, down, 00 + tick -> 99, carry=1; SAT=1, 99 + up tick -> 99, carry=1.
REQ-035 SHALL cover: en=1, key_n held low for 20 cycles -> exactly one increment, 3 edges after the first low sample; tick pulses ignored.
REQ-036 SHALL cover: load=1 and tick on the same cycle with load_val=0x3C, BASE=10 -> cnt_val=0x39, no carry.
REQ-037 SHALL cover: rst=0 asserted mid-count with tick=1 -> cnt_val=0, scan=01, seg=3F next edge.
REQ-038 SHALL cover: NDIG=4, scan cycles 0001, 0010, 0100, 1000, 0001, with seg matching each digit of 0x1A2F.
